// File: rtl/wb_cmd_master_pkg.sv
// Shared definitions for the command-driven Wishbone initiator: FSM state
// encoding, lane-selection constants for the 128-bit bus and timeout defaults.
package wb_cmd_master_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // In 128-bit mode the 32-bit lane is chosen by byte-address bits [3:2].
   localparam int LANE_SEL_LSB = 2;
   localparam int LANE_SEL_MSB = 3;
   localparam int LANES_128    = 4;

   localparam int DEFAULT_TIMEOUT = 255;

   // Timeout counter width; kept at least 1 bit so a disabled timeout (0)
   // still yields a legal vector.
   function automatic int tmo_cnt_width(input int timeout_cycles);
      int w;
      w = $clog2(timeout_cycles + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/wb_lane_mux.sv
// 32-bit command word <-> Wishbone data bus lane steering. Pure combinational.
// For a 128-bit bus: write data replicated on all lanes, byte selects shifted
// to the addressed lane, read data taken from the addressed lane.
module wb_lane_mux
   import wb_cmd_master_pkg::*;
#(
   parameter int WB_DWIDTH = 32,
   parameter int WB_SWIDTH = 4
) (
   input  logic [1:0]           lane_i,
   input  logic [31:0]          wr_dat_i,
   input  logic [3:0]           wr_sel_i,
   input  logic [WB_DWIDTH-1:0] wb_rd_dat_i,
   output logic [WB_DWIDTH-1:0] wb_wr_dat_o,
   output logic [WB_SWIDTH-1:0] wb_sel_o,
   output logic [31:0]          rd_dat_o
);

   generate
      if (WB_DWIDTH == 128) begin : g_wide
         assign wb_wr_dat_o = {LANES_128{wr_dat_i}};
         assign wb_sel_o    = {12'b0, wr_sel_i} << {lane_i, 2'b00};

         // Pick the 32-bit read lane addressed by the latched address bits.
         always_comb begin
            rd_dat_o = wb_rd_dat_i[31:0];
            case (lane_i)
               2'd1:    rd_dat_o = wb_rd_dat_i[63:32];
               2'd2:    rd_dat_o = wb_rd_dat_i[95:64];
               2'd3:    rd_dat_o = wb_rd_dat_i[127:96];
               default: rd_dat_o = wb_rd_dat_i[31:0];
            endcase
         end
      end else begin : g_narrow
         logic unused_lane;
         assign unused_lane = &{1'b0, lane_i};
         assign wb_wr_dat_o = wr_dat_i;
         assign wb_sel_o    = wr_sel_i;
         assign rd_dat_o    = wb_rd_dat_i;
      end
   endgenerate

endmodule

// File: rtl/wb_cmd_master.sv
// Command-driven Wishbone classic single-cycle initiator.
//
// Handshakes: both the command port (i_cmd_valid/o_cmd_ready) and the response
// port (o_rsp_valid/i_rsp_ready) transfer exactly on a rising edge where valid
// and ready are both high. A producer holds valid and its payload stable until
// that edge; ready may be asserted independently of valid.
//
// cyc/stb are registered and fall at the edge where ack/err is sampled, so a
// slave that builds ack combinationally from stb never sees a second strobe.
module wb_cmd_master
   import wb_cmd_master_pkg::*;
#(
   parameter int WB_DWIDTH      = 32,
   parameter int WB_SWIDTH      = 4,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_cmd_valid,
   output logic                 o_cmd_ready,
   input  logic                 i_cmd_we,
   input  logic [31:0]          i_cmd_adr,
   input  logic [31:0]          i_cmd_dat,
   input  logic [3:0]           i_cmd_sel,
   output logic                 o_rsp_valid,
   input  logic                 i_rsp_ready,
   output logic [31:0]          o_rsp_dat,
   output logic                 o_rsp_err,
   output logic                 o_rsp_timeout,
   output logic [31:0]          o_wb_adr,
   output logic [WB_SWIDTH-1:0] o_wb_sel,
   output logic                 o_wb_we,
   output logic [WB_DWIDTH-1:0] o_wb_dat,
   input  logic [WB_DWIDTH-1:0] i_wb_dat,
   output logic                 o_wb_cyc,
   output logic                 o_wb_stb,
   input  logic                 i_wb_ack,
   input  logic                 i_wb_err,
   output logic [1:0]           o_dbg_state
);

   localparam int               CNT_W     = tmo_cnt_width(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

   state_e             state_q;
   logic [31:0]        adr_q;
   logic [31:0]        dat_q;
   logic [3:0]         sel_q;
   logic               we_q;
   logic               cyc_q;
   logic               rsp_valid_q;
   logic [31:0]        rsp_dat_q;
   logic               rsp_err_q;
   logic               rsp_to_q;
   logic [CNT_W-1:0]   tmo_cnt_q;
   logic [CNT_W-1:0]   tmo_cnt_d;
   logic [31:0]        rd_dat;
   logic               cmd_accept;

   wb_lane_mux #(
      .WB_DWIDTH (WB_DWIDTH),
      .WB_SWIDTH (WB_SWIDTH)
   ) u_lane_mux (
      .lane_i      (adr_q[LANE_SEL_MSB:LANE_SEL_LSB]),
      .wr_dat_i    (dat_q),
      .wr_sel_i    (sel_q),
      .wb_rd_dat_i (i_wb_dat),
      .wb_wr_dat_o (o_wb_dat),
      .wb_sel_o    (o_wb_sel),
      .rd_dat_o    (rd_dat)
   );

   // Ready is gated by reset so it reads 0 during reset and 1 in the very
   // first cycle after reset is released.
   assign o_cmd_ready = (state_q == ST_IDLE) & ~i_rst;
   assign cmd_accept  = i_cmd_valid & o_cmd_ready;

   // Next value of the strobe-cycle counter.
   always_comb begin
      tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
   end

   // Request/bus/response FSM with all outputs registered.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= ST_IDLE;
         adr_q       <= '0;
         dat_q       <= '0;
         sel_q       <= '0;
         we_q        <= 1'b0;
         cyc_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_dat_q   <= '0;
         rsp_err_q   <= 1'b0;
         rsp_to_q    <= 1'b0;
         tmo_cnt_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cmd_accept) begin
                  adr_q     <= i_cmd_adr;
                  dat_q     <= i_cmd_dat;
                  sel_q     <= i_cmd_sel;
                  we_q      <= i_cmd_we;
                  cyc_q     <= 1'b1;
                  tmo_cnt_q <= '0;
                  state_q   <= ST_BUS;
               end
            end
            ST_BUS: begin
               if (i_wb_err) begin
                  // err wins over a simultaneous ack; no data is returned
                  cyc_q       <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
                  rsp_dat_q   <= '0;
                  state_q     <= ST_RESP;
               end else if (i_wb_ack) begin
                  cyc_q       <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_dat_q   <= we_q ? 32'h0 : rd_dat;
                  state_q     <= ST_RESP;
               end else if ((TIMEOUT_CYCLES != 0) && (tmo_cnt_d == TMO_LIMIT)) begin
                  cyc_q       <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_to_q    <= 1'b1;
                  rsp_dat_q   <= '0;
                  state_q     <= ST_RESP;
               end else begin
                  tmo_cnt_q <= tmo_cnt_d;
               end
            end
            ST_RESP: begin
               if (i_rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  rsp_dat_q   <= '0;
                  rsp_err_q   <= 1'b0;
                  rsp_to_q    <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               cyc_q       <= 1'b0;
               rsp_valid_q <= 1'b0;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_wb_adr      = adr_q;
   assign o_wb_we       = we_q;
   assign o_wb_cyc      = cyc_q;
   assign o_wb_stb      = cyc_q;
   assign o_rsp_valid   = rsp_valid_q;
   assign o_rsp_dat     = rsp_dat_q;
   assign o_rsp_err     = rsp_err_q;
   assign o_rsp_timeout = rsp_to_q;
   assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: a 32-bit and a 128-bit instance share the command,
// response-ready and ack/err stimulus; each is checked against hand-computed
// table values plus hand-written reset and stray-ack sequences.
module tb_wb_cmd_master;

   localparam int TMO = 8;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // ---------------- shared stimulus ----------------
   logic        cmd_valid, cmd_we, rsp_ready, wb_ack, wb_err;
   logic [31:0] cmd_adr, cmd_dat;
   logic [3:0]  cmd_sel;

   // 32-bit instance
   logic        a_cmd_ready, a_rsp_valid, a_rsp_err, a_rsp_timeout;
   logic        a_wb_we, a_wb_cyc, a_wb_stb;
   logic [31:0] a_rsp_dat, a_wb_adr, a_wb_dat, a_wb_rdat;
   logic [3:0]  a_wb_sel;
   logic [1:0]  a_dbg;

   // 128-bit instance
   logic         b_cmd_ready, b_rsp_valid, b_rsp_err, b_rsp_timeout;
   logic         b_wb_we, b_wb_cyc, b_wb_stb;
   logic [31:0]  b_rsp_dat, b_wb_adr;
   logic [127:0] b_wb_dat, b_wb_rdat;
   logic [15:0]  b_wb_sel;
   logic [1:0]   b_dbg;

   wb_cmd_master #(.WB_DWIDTH(32), .WB_SWIDTH(4), .TIMEOUT_CYCLES(TMO)) dut_a (
      .i_clk(clk), .i_rst(rst),
      .i_cmd_valid(cmd_valid), .o_cmd_ready(a_cmd_ready), .i_cmd_we(cmd_we),
      .i_cmd_adr(cmd_adr), .i_cmd_dat(cmd_dat), .i_cmd_sel(cmd_sel),
      .o_rsp_valid(a_rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_dat(a_rsp_dat),
      .o_rsp_err(a_rsp_err), .o_rsp_timeout(a_rsp_timeout),
      .o_wb_adr(a_wb_adr), .o_wb_sel(a_wb_sel), .o_wb_we(a_wb_we), .o_wb_dat(a_wb_dat),
      .i_wb_dat(a_wb_rdat), .o_wb_cyc(a_wb_cyc), .o_wb_stb(a_wb_stb),
      .i_wb_ack(wb_ack), .i_wb_err(wb_err), .o_dbg_state(a_dbg)
   );

   wb_cmd_master #(.WB_DWIDTH(128), .WB_SWIDTH(16), .TIMEOUT_CYCLES(TMO)) dut_b (
      .i_clk(clk), .i_rst(rst),
      .i_cmd_valid(cmd_valid), .o_cmd_ready(b_cmd_ready), .i_cmd_we(cmd_we),
      .i_cmd_adr(cmd_adr), .i_cmd_dat(cmd_dat), .i_cmd_sel(cmd_sel),
      .o_rsp_valid(b_rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_dat(b_rsp_dat),
      .o_rsp_err(b_rsp_err), .o_rsp_timeout(b_rsp_timeout),
      .o_wb_adr(b_wb_adr), .o_wb_sel(b_wb_sel), .o_wb_we(b_wb_we), .o_wb_dat(b_wb_dat),
      .i_wb_dat(b_wb_rdat), .o_wb_cyc(b_wb_cyc), .o_wb_stb(b_wb_stb),
      .i_wb_ack(wb_ack), .i_wb_err(wb_err), .o_dbg_state(b_dbg)
   );

   // ---------------- scoreboard ----------------
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // kind: 0 = ack, 1 = err, 2 = ack+err together, 3 = never respond
   typedef struct {
      logic         we;
      logic [31:0]  adr;
      logic [31:0]  dat;
      logic [3:0]   sel;
      int           ws;
      int           kind;
      int           rsp_delay;
      logic [31:0]  rd32;
      logic [127:0] rd128;
      int           exp_stb;
      logic [31:0]  exp_dat32;
      logic [31:0]  exp_dat128;
      logic         exp_err;
      logic         exp_to;
      logic [15:0]  exp_sel128;
   } vec_t;

   vec_t vecs[8];

   // ---------------- driver tasks ----------------
   task automatic run_vec(input int idx);
      vec_t v;
      int   stb_cnt;
      int   lat;
      logic got;
      logic [31:0] exp_d;
      v = vecs[idx];
      a_wb_rdat = v.rd32;
      b_wb_rdat = v.rd128;
      exp_q.push_back(v.exp_dat32);
      @(negedge clk);
      check($sformatf("v%0d ready_idle", idx), {a_cmd_ready, b_cmd_ready}, 2'b11);
      cmd_valid = 1'b1;
      cmd_we    = v.we;
      cmd_adr   = v.adr;
      cmd_dat   = v.dat;
      cmd_sel   = v.sel;
      stb_cnt   = 0;
      lat       = 0;
      got       = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
         @(negedge clk);
         cmd_valid = 1'b0;
         wb_ack    = 1'b0;
         wb_err    = 1'b0;
         lat++;
         if (a_rsp_valid) begin
            got = 1'b1;
         end else if (a_wb_stb) begin
            stb_cnt++;
            check($sformatf("v%0d bus_a", idx), {a_wb_adr, a_wb_we, a_wb_sel, a_wb_dat, a_wb_cyc, a_cmd_ready},
                  {v.adr, v.we, v.sel, v.dat, 1'b1, 1'b0});
            check($sformatf("v%0d bus_b_sel", idx), {b_wb_stb, b_wb_sel, b_wb_adr}, {1'b1, v.exp_sel128, v.adr});
            check($sformatf("v%0d bus_b_dat", idx), b_wb_dat, {v.dat, v.dat, v.dat, v.dat});
            if (stb_cnt == v.ws + 1) begin
               case (v.kind)
                  0: wb_ack = 1'b1;
                  1: wb_err = 1'b1;
                  2: begin wb_ack = 1'b1; wb_err = 1'b1; end
                  default: ;
               endcase
            end
         end
      end
      wb_ack = 1'b0;
      wb_err = 1'b0;
      check($sformatf("v%0d rsp_seen", idx), got, 1'b1);
      check($sformatf("v%0d stb_cycles", idx), stb_cnt, v.exp_stb);
      check($sformatf("v%0d latency", idx), lat, v.exp_stb + 1);
      exp_d = exp_q.pop_front();
      for (int d = 0; d <= v.rsp_delay; d++) begin
         if (d > 0) @(negedge clk);
         check($sformatf("v%0d rsp_a", idx), {a_rsp_valid, a_rsp_dat, a_rsp_err, a_rsp_timeout, a_wb_stb, a_cmd_ready, a_dbg},
               {1'b1, exp_d, v.exp_err, v.exp_to, 1'b0, 1'b0, 2'd2});
         check($sformatf("v%0d rsp_b", idx), {b_rsp_valid, b_rsp_dat, b_rsp_err, b_rsp_timeout, b_wb_stb},
               {1'b1, v.exp_dat128, v.exp_err, v.exp_to, 1'b0});
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check($sformatf("v%0d after_rsp", idx), {a_rsp_valid, a_rsp_dat, a_rsp_err, a_rsp_timeout, a_cmd_ready, a_dbg},
            {1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 2'd0});
      check($sformatf("v%0d after_rsp_b", idx), {b_rsp_valid, b_rsp_err, b_rsp_timeout, b_cmd_ready}, 4'b0001);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      //            we    adr           dat           sel   ws kd dly rd32          rd128                                        stb exp32         exp128        err   to    sel128
      vecs[0] = '{1'b1, 32'h1400_0010, 32'h0000_0006, 4'hF, 0, 0, 0, 32'hDEAD_DEAD, 128'h0,                                     1, 32'h0,        32'h0,        1'b0, 1'b0, 16'h000F};
      vecs[1] = '{1'b0, 32'h1400_0004, 32'h0,         4'hF, 2, 0, 2, 32'h2233_4455, 128'h11111111_00000000_22334455_AAAAAAAA,   3, 32'h2233_4455, 32'h2233_4455, 1'b0, 1'b0, 16'h00F0};
      vecs[2] = '{1'b0, 32'h1400_0008, 32'h0,         4'hF, 1, 2, 0, 32'h9999_9999, 128'h99999999_99999999_99999999_99999999,   2, 32'h0,        32'h0,        1'b1, 1'b0, 16'h0F00};
      vecs[3] = '{1'b0, 32'h1400_000C, 32'h0,         4'hF, 0, 3, 1, 32'h7777_7777, 128'h77777777_77777777_77777777_77777777, TMO, 32'h0,        32'h0,        1'b0, 1'b1, 16'hF000};
      vecs[4] = '{1'b0, 32'h2000_000C, 32'h0,         4'hF, 0, 0, 0, 32'hCAFE_F00D, 128'hDEADBEEF_33333333_22222222_11111111,   1, 32'hCAFE_F00D, 32'hDEAD_BEEF, 1'b0, 1'b0, 16'hF000};
      vecs[5] = '{1'b1, 32'h2000_0008, 32'h1234_5678, 4'h3, 1, 0, 0, 32'h0,         128'h0,                                     2, 32'h0,        32'h0,        1'b0, 1'b0, 16'h0300};
      vecs[6] = '{1'b1, 32'h0000_0003, 32'hA5A5_A5A5, 4'h0, 0, 1, 1, 32'h0,         128'h0,                                     1, 32'h0,        32'h0,        1'b1, 1'b0, 16'h0000};
      vecs[7] = '{1'b0, 32'h3000_0008, 32'h0,         4'hC, 3, 0, 0, 32'h0BAD_F00D, 128'h00000000_55AA55AA_FFFFFFFF_00000000,   4, 32'h0BAD_F00D, 32'h55AA_55AA, 1'b0, 1'b0, 16'h0C00};

      rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
      rsp_ready = 1'b0; wb_ack = 1'b0; wb_err = 1'b0; a_wb_rdat = '0; b_wb_rdat = '0;

      // reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_ctrl_a", {a_cmd_ready, a_wb_cyc, a_wb_stb, a_wb_we, a_rsp_valid, a_rsp_err, a_rsp_timeout}, 7'b0);
      check("reset_data_a", {a_wb_adr, a_wb_sel, a_wb_dat, a_rsp_dat}, 100'h0);
      check("reset_b", {b_cmd_ready, b_wb_cyc, b_wb_sel, b_wb_dat, b_rsp_valid}, 147'h0);
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_reset", {a_cmd_ready, b_cmd_ready, a_dbg}, {2'b11, 2'd0});

      // stray ack/err in IDLE has no effect
      wb_ack = 1'b1; wb_err = 1'b1;
      repeat (2) @(negedge clk);
      wb_ack = 1'b0; wb_err = 1'b0;
      check("stray_idle", {a_rsp_valid, a_rsp_err, a_wb_cyc, a_cmd_ready, a_dbg}, {4'b0001, 2'd0});

      // table of single transactions
      for (int i = 0; i < 8; i++) run_vec(i);

      // reset while the bus cycle is open; the late ack must be ignored
      @(negedge clk);
      a_wb_rdat = 32'h5A5A_5A5A;
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h1400_0020; cmd_sel = 4'hF;
      @(negedge clk);
      cmd_valid = 1'b0;
      check("midrst_stb_open", {a_wb_stb, b_wb_stb}, 2'b11);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_bus_drop", {a_wb_cyc, a_wb_stb, b_wb_cyc, b_wb_stb, a_rsp_valid, b_rsp_valid}, 6'b0);
      check("midrst_adr_clr", a_wb_adr, 32'h0);
      wb_ack = 1'b1;
      @(negedge clk);
      wb_ack = 1'b0;
      check("midrst_stray_ack", {a_rsp_valid, a_wb_cyc, a_cmd_ready, b_cmd_ready, a_dbg}, {4'b0011, 2'd0});
      @(negedge clk);
      check("midrst_no_rsp", {a_rsp_valid, b_rsp_valid, a_rsp_dat}, 34'h0);

      // one more transaction after the aborted one
      run_vec(4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
